// File: rtl/fb_clear_scheduler.sv
// Frame-buffer port arbiter: a raster-order background-restore sweep (1-bit RAM
// expanded to CW bits) preempts single-pixel writes from the draw client.
module fb_clear_scheduler #(
   parameter int H_PIX = 160,
   parameter int V_PIX = 120,
   parameter int CW    = 12
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          frame_start,
   output logic [14:0]   bg_addr,
   input  logic          bg_q,
   input  logic          draw_req,
   input  logic [7:0]    draw_x,
   input  logic [7:0]    draw_y,
   input  logic [CW-1:0] draw_color,
   output logic          draw_ack,
   output logic          fb_we,
   output logic [7:0]    fb_x,
   output logic [7:0]    fb_y,
   output logic [CW-1:0] fb_color,
   output logic          busy,
   output logic          clear_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_FLUSH
   } state_t;

   localparam logic [7:0]  X_LAST = 8'(H_PIX - 1);
   localparam logic [7:0]  Y_LAST = 8'(V_PIX - 1);
   localparam logic [14:0] LINE   = 15'(H_PIX);

   state_t        r_state,  w_state_nxt;
   logic [7:0]    r_x,      w_x_nxt;
   logic [7:0]    r_y,      w_y_nxt;
   logic          r_we,     w_we_nxt;
   logic          r_src_bg, w_src_bg_nxt;
   logic [7:0]    r_fb_x,   w_fb_x_nxt;
   logic [7:0]    r_fb_y,   w_fb_y_nxt;
   logic [CW-1:0] r_color,  w_color_nxt;
   logic          r_ack,    w_ack_nxt;
   logic          r_done,   w_done_nxt;

   logic          w_last_pix;
   logic          w_draw_in_range;
   logic [CW-1:0] w_bg_color;

   assign w_bg_color      = {CW{bg_q}};
   assign w_last_pix      = (r_x == X_LAST) && (r_y == Y_LAST);
   assign w_draw_in_range = (draw_x <= X_LAST) && (draw_y <= Y_LAST);
   assign bg_addr         = 15'(r_y) * LINE + 15'(r_x);

   always_comb begin
      // NOTE: every signal gets a default first so no branch can infer a latch.
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_we_nxt     = 1'b0;
      w_src_bg_nxt = r_src_bg;
      w_fb_x_nxt   = r_fb_x;
      w_fb_y_nxt   = r_fb_y;
      w_color_nxt  = r_color;
      w_ack_nxt    = 1'b0;
      w_done_nxt   = 1'b0;

      // Capture the RAM pixel on screen so fb_color still holds it after fb_we drops.
      if (r_we && r_src_bg) begin
         w_color_nxt = w_bg_color;
      end

      case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_state_nxt = S_CLEAR;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end else if (draw_req) begin
               w_ack_nxt = 1'b1;
               if (w_draw_in_range) begin
                  w_we_nxt     = 1'b1;
                  w_src_bg_nxt = 1'b0;
                  w_fb_x_nxt   = draw_x;
                  w_fb_y_nxt   = draw_y;
                  w_color_nxt  = draw_color;
               end
            end
         end

         S_CLEAR: begin
            w_we_nxt     = 1'b1;
            w_src_bg_nxt = 1'b1;
            w_fb_x_nxt   = r_x;
            w_fb_y_nxt   = r_y;
            if (frame_start) begin
               w_x_nxt = '0;
               w_y_nxt = '0;
            end else if (w_last_pix) begin
               w_state_nxt = S_FLUSH;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end else if (r_x == X_LAST) begin
               w_x_nxt = '0;
               w_y_nxt = r_y + 8'd1;
            end else begin
               w_x_nxt = r_x + 8'd1;
            end
         end

         S_FLUSH: begin
            if (frame_start) begin
               w_state_nxt = S_CLEAR;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_we     <= 1'b0;
         r_src_bg <= 1'b0;
         r_fb_x   <= '0;
         r_fb_y   <= '0;
         r_color  <= '0;
         r_ack    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_we     <= w_we_nxt;
         r_src_bg <= w_src_bg_nxt;
         r_fb_x   <= w_fb_x_nxt;
         r_fb_y   <= w_fb_y_nxt;
         r_color  <= w_color_nxt;
         r_ack    <= w_ack_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign fb_we      = r_we;
   assign fb_x       = r_fb_x;
   assign fb_y       = r_fb_y;
   assign fb_color   = (r_we && r_src_bg) ? w_bg_color : r_color;
   assign draw_ack   = r_ack;
   assign clear_done = r_done;
   assign busy       = (r_state != S_IDLE);

endmodule
